// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs feeding one registered broadcast.
// Define CDB_RR_ARB_EN for round-robin arbitration; otherwise lowest index wins.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_idx;
    logic [4:0]  rd_addr;
    logic [31:0] data;
  } cdb_t;

  typedef struct packed {
    logic [4:0]  rob_idx;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] data;
  } cdb_ent_t;
endpackage

module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  cdb_ent_t din,
  output cdb_ent_t dout,
  output logic     empty,
  output logic     full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  cdb_ent_t      mem_q [DEPTH];
  cdb_ent_t      mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Caller guarantees push only when !full and pop only when !empty.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign dout  = mem_q[rptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
endmodule

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_SRC-1:0]       fu_valid,
  output logic [NUM_SRC-1:0]       fu_ready,
  input  logic [NUM_SRC-1:0][4:0]  fu_rob_idx,
  input  logic [NUM_SRC-1:0][4:0]  fu_rd_addr,
  input  logic [NUM_SRC-1:0]       fu_regf_we,
  input  logic [NUM_SRC-1:0][31:0] fu_data,
  output cdb_t                     cdbus
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] push, pop, ne, full;
  cdb_ent_t           head [NUM_SRC];
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;
  cdb_t               cdbus_q, cdbus_d;

  // A full buffer stays not-ready even if popped this cycle.
  assign fu_ready = ~full & {NUM_SRC{~rst & ~flush}};
  assign push     = fu_valid & fu_ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cdb_ent_t din;
    logic     empty;
    assign din.rob_idx = fu_rob_idx[g];
    assign din.rd_addr = fu_rd_addr[g];
    assign din.regf_we = fu_regf_we[g];
    assign din.data    = fu_data[g];

    cdb_src_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (din),
      .dout  (head[g]),
      .empty (empty),
      .full  (full[g])
    );
    assign ne[g] = ~empty;
  end

`ifdef CDB_RR_ARB_EN
  logic [IW-1:0] rr_q, rr_d;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_SRC;
    return IW'(s);
  endfunction

  // Walk downwards so the nearest source after the last grant is assigned last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (ne[rr_idx(rr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx(rr_q, k);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld && !flush) rr_d = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (ne[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    pop = '0;
    if (gnt_vld && !flush) pop[gnt_idx] = 1'b1;
  end

  // Payload fields hold when nothing is broadcast; non-writing results carry rd 0.
  always_comb begin
    cdbus_d       = cdbus_q;
    cdbus_d.valid = 1'b0;
    if (gnt_vld && !flush) begin
      cdbus_d.valid   = 1'b1;
      cdbus_d.rob_idx = head[gnt_idx].rob_idx;
      cdbus_d.rd_addr = head[gnt_idx].regf_we ? head[gnt_idx].rd_addr : 5'd0;
      cdbus_d.data    = head[gnt_idx].data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cdbus_q <= '0;
    else     cdbus_q <= cdbus_d;
  end

  assign cdbus = cdbus_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_SRC=3, BUF_DEPTH=2).
module tb_cdb_arbiter;
  import cdb_pkg::*;
  localparam int NS = 3;

  logic                clk = 1'b0;
  logic                rst, flush;
  logic [NS-1:0]       fu_valid, fu_ready, fu_regf_we;
  logic [NS-1:0][4:0]  fu_rob_idx, fu_rd_addr;
  logic [NS-1:0][31:0] fu_data;
  cdb_t                cdbus;
  int                  checks = 0;
  int                  errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(NS), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_ready   (fu_ready),
    .fu_rob_idx (fu_rob_idx),
    .fu_rd_addr (fu_rd_addr),
    .fu_regf_we (fu_regf_we),
    .fu_data    (fu_data),
    .cdbus      (cdbus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fu_valid   = '0;
    fu_rob_idx = '0;
    fu_rd_addr = '0;
    fu_regf_we = '0;
    fu_data    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; idle_inputs();
    tick(); tick();
    checks++;
    if (cdbus !== '0) begin errors++; $display("FAIL reset_cdbus got %h want 0", cdbus); end
    checks++;
    if (fu_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", fu_ready); end
    rst = 1'b0; #1;
    checks++;
    if (fu_ready !== 3'b111) begin errors++; $display("FAIL release_ready got %b want 111", fu_ready); end
  endtask

  task automatic test_single();
    cdb_t exp;
    fu_valid = 3'b001; fu_rob_idx[0] = 5'd3; fu_rd_addr[0] = 5'd5;
    fu_regf_we[0] = 1'b1; fu_data[0] = 32'h11;
    tick();
    idle_inputs();
    checks++;
    if (cdbus.valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", cdbus.valid); end
    tick();
    exp = '{valid: 1'b1, rob_idx: 5'd3, rd_addr: 5'd5, data: 32'h11};
    checks++;
    if (cdbus !== exp) begin errors++; $display("FAIL single_bcast got %h want %h", cdbus, exp); end
    tick();
    exp.valid = 1'b0;
    checks++;
    if (cdbus !== exp) begin errors++; $display("FAIL single_idle_hold got %h want %h", cdbus, exp); end
  endtask

  task automatic test_no_regf();
    int          src [2]    = '{1, 2};
    logic [4:0]  rob [2]    = '{5'd7, 5'd12};
    logic [4:0]  rd  [2]    = '{5'd9, 5'd20};
    logic        we  [2]    = '{1'b0, 1'b1};
    logic [31:0] dat [2]    = '{32'hDEAD_BEEF, 32'h1234_5678};
    logic [4:0]  exp_rd [2] = '{5'd0, 5'd20};
    cdb_t exp;
    for (int t = 0; t < 2; t++) begin
      idle_inputs();
      fu_valid[src[t]]   = 1'b1;
      fu_rob_idx[src[t]] = rob[t];
      fu_rd_addr[src[t]] = rd[t];
      fu_regf_we[src[t]] = we[t];
      fu_data[src[t]]    = dat[t];
      tick();
      idle_inputs();
      tick();
      exp = '{valid: 1'b1, rob_idx: rob[t], rd_addr: exp_rd[t], data: dat[t]};
      checks++;
      if (cdbus !== exp) begin errors++; $display("FAIL regf_we_case%0d got %h want %h", t, cdbus, exp); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int   sent [2];
    int   got [2];
    bit   acc [2];
    bit   saw_full;
    int   last_src;
    int   s, n;
    sent = '{0, 0}; got = '{0, 0}; saw_full = 1'b0; last_src = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
        fu_valid[i]   = (sent[i] < 8);
        fu_rob_idx[i] = 5'(i * 8 + sent[i]);
        fu_rd_addr[i] = 5'(sent[i] + 1);
        fu_regf_we[i] = 1'b1;
        fu_data[i]    = 32'hA000_0000 | 32'(i << 8) | 32'(sent[i]);
        acc[i]        = fu_valid[i] && fu_ready[i];
        if (fu_valid[i] && !fu_ready[i]) saw_full = 1'b1;
      end
      tick();
      for (int i = 0; i < 2; i++) if (acc[i]) sent[i]++;
      if (cdbus.valid === 1'b1) begin
        s = int'(cdbus.rob_idx[4:3]);
        n = int'(cdbus.rob_idx[2:0]);
        checks++;
        if (s > 1 || n != got[s & 1]) begin
          errors++; $display("FAIL b2b_order got src%0d #%0d want #%0d", s, n, got[s & 1]);
        end
        checks++;
        if (cdbus.rd_addr !== 5'(n + 1) || cdbus.data !== (32'hA000_0000 | 32'(s << 8) | 32'(n))) begin
          errors++; $display("FAIL b2b_payload got rd %0d data %h for src%0d #%0d", cdbus.rd_addr, cdbus.data, s, n);
        end
`ifdef CDB_RR_ARB_EN
        checks++;
        if (got[0] < 8 && got[1] < 8 && s == last_src) begin
          errors++; $display("FAIL b2b_rr_alternate got src%0d twice want other source", s);
        end
`else
        checks++;
        if (s == 1 && got[0] != 8) begin
          errors++; $display("FAIL b2b_priority got src1 with %0d src0 done want 8", got[0]);
        end
`endif
        last_src = s;
        got[s & 1]++;
      end
      if (got[0] >= 8 && got[1] >= 8) break;
    end
    idle_inputs();
    tick();
    checks++;
    if (cdbus.valid !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid got %b want 0", cdbus.valid); end
    checks++;
    if (got[0] != 8 || got[1] != 8) begin
      errors++; $display("FAIL b2b_count got %0d/%0d want 8/8", got[0], got[1]);
    end
    checks++;
    if (!saw_full) begin errors++; $display("FAIL b2b_ready_drop got never low want low once full"); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NS; i++) begin
        fu_valid[i]   = 1'b1;
        fu_rob_idx[i] = 5'(16 + i * 4 + c);
        fu_rd_addr[i] = 5'(i + 1);
        fu_regf_we[i] = 1'b1;
        fu_data[i]    = 32'(c);
      end
      tick();
    end
    flush = 1'b1;
    #1;
    checks++;
    if (fu_ready !== 3'b000) begin errors++; $display("FAIL flush_ready_low got %b want 000", fu_ready); end
    tick();
    flush = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (cdbus.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", cdbus.valid); end
    checks++;
    if (fu_ready !== 3'b111) begin errors++; $display("FAIL flush_ready got %b want 111", fu_ready); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (cdbus.valid !== 1'b0) begin
        errors++; $display("FAIL flush_stale cyc%0d got rob %0d want no broadcast", c, cdbus.rob_idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    fu_valid = 3'b101; fu_regf_we = 3'b101;
    fu_rob_idx[0] = 5'd1; fu_rob_idx[2] = 5'd28; fu_data[0] = 32'h1; fu_data[2] = 32'h28;
    tick();
    fu_rob_idx[0] = 5'd2; fu_rob_idx[2] = 5'd29; fu_data[0] = 32'h2; fu_data[2] = 32'h29;
    tick();
`ifndef CDB_RR_ARB_EN
    checks++;
    if (fu_ready[2] !== 1'b0) begin errors++; $display("FAIL mid_src2_full got ready %b want 0", fu_ready[2]); end
`endif
    rst = 1'b1;
    fu_rob_idx[2] = 5'd30;
    #1;
    checks++;
    if (fu_ready !== 3'b000) begin errors++; $display("FAIL mid_rst_ready got %b want 000", fu_ready); end
    tick();
    checks++;
    if (cdbus !== '0) begin errors++; $display("FAIL mid_rst_cdbus got %h want 0", cdbus); end
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (fu_ready !== 3'b111) begin errors++; $display("FAIL mid_release_ready got %b want 111", fu_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (cdbus.valid !== 1'b0) begin
        errors++; $display("FAIL mid_stale cyc%0d got rob %0d want no broadcast", c, cdbus.rob_idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_no_regf();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of functional-unit result sources (index 0 = integer ALU, 1 = load/store, 2 = mul/div).
REQ-002 SHALL have parameter BUF_DEPTH, default 2, per-source result buffer entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  pipeline flush; discards all buffered and in-flight results.
REQ-006 SHALL have port fu_valid  input  NUM_SRC  per-source result valid.
REQ-007 SHALL have port fu_ready  output  NUM_SRC  per-source result accept.
REQ-008 SHALL have port fu_rob_idx  input  NUM_SRC x 5  ROB index of each result.
REQ-009 SHALL have port fu_rd_addr  input  NUM_SRC x 5  architectural destination of each result.
REQ-010 SHALL have port fu_regf_we  input  NUM_SRC  result writes the register file.
REQ-011 SHALL have port fu_data  input  NUM_SRC x 32  result value.
REQ-012 SHALL have port cdbus  output  cdb  registered broadcast with fields valid, rob_idx[4:0], rd_addr[4:0], data[31:0].

Function
REQ-013 SHALL keep one FIFO of BUF_DEPTH entries per source, storing {rob_idx, rd_addr, regf_we, data}.
REQ-014 SHALL drive fu_ready[i] = (count[i] < BUF_DEPTH) && !rst && !flush; a full buffer deasserts ready even when it is popped in the same cycle.
REQ-015 SHALL push source i at the clock edge when fu_valid[i] && fu_ready[i]; fu_valid with fu_ready low is ignored (the source holds its result).
REQ-016 SHALL, each cycle, grant exactly one non-empty buffer, pop its head at the edge, and load the head into the cdbus register with valid=1.
REQ-017 SHALL load cdbus.valid=0 at the edge when all buffers are empty; rob_idx, rd_addr and data SHALL then hold their previous values.
REQ-018 SHALL broadcast rd_addr=0 when the granted entry has regf_we=0, so that stores and branches complete in the ROB without waking dependents.
REQ-019 SHALL have fixed latency of 2: a result accepted at edge N into an empty system appears on cdbus during the cycle after edge N+1.
REQ-020 SHALL allow a simultaneous push and pop on the same buffer when not full; count is unchanged and FIFO order is preserved.
REQ-021 SHALL wrap read and write pointers modulo BUF_DEPTH.
REQ-022 SHALL never drop, duplicate or reorder results within a source; results from different sources are ordered only by arbitration.
REQ-023 SHALL, on flush, empty all buffers and load cdbus.valid=0 at that edge; pushes in the flush cycle are discarded.

Reset
REQ-024 SHALL, on an edge with rst=1, empty all buffers, clear pointers and counts, zero all cdbus fields, and set the round-robin pointer to 0.
REQ-025 SHALL drive fu_ready=0 while rst=1; rst asserted mid-operation discards all pending results, including any pending push in that cycle.

Configuration
REQ-026 SHALL, with macro CDB_RR_ARB_EN defined, use round-robin arbitration: search starts at the source after the last granted one, wrapping modulo NUM_SRC; the pointer updates only on a grant.
REQ-027 SHALL, without CDB_RR_ARB_EN, use fixed priority, with the lowest non-empty index winning; no round-robin pointer is built.

Verification
REQ-028 SHALL cover: after reset, src0 pushes rob 3, rd 5, data 0x11 -> cdbus {1,3,5,0x11} exactly two cycles later, then valid=0.
REQ-029 SHALL cover: src0 and src1 push every cycle for 8 cycles -> fu_ready drops once buffers fill; all 16 results broadcast exactly once, in per-source order; with CDB_RR_ARB_EN grants alternate 0,1,0,1; without it, src0 drains first.
REQ-030 SHALL cover: src1 pushes rob 7, regf_we=0, rd 9 -> cdbus {1,7,0,data}.
REQ-031 SHALL cover: fill all buffers, assert flush one cycle -> next cycle cdbus.valid=0, fu_ready all 1, no flushed rob_idx ever appears.
REQ-032 SHALL cover: rst asserted while src2 has 2 buffered results -> cdbus all zero after the edge, fu_ready=0 during rst, no stale result broadcast after release.
